vehicle_plant: RTL and testbench
================================

# vehicle_plant

Behavioural vehicle model on the actuator side of the cruise-control loop. It consumes the controller's `fuel` command and `brake` request and produces the measured `speed` the controller compares against its set point. It integrates acceleration minus drag over fixed physics ticks, tracks a motion state and accumulates distance. It closes the loop so the controller can be exercised in closed-loop simulation and on board.

## Interface
Parameters:
- `MAX_SPEED`, 200: speed saturation ceiling; must be ≤ 255.
- `UPDATE_DIV`, 4: clock cycles per physics tick; must be ≥ 2.
- `DRAG`, 1: speed lost per tick with no brake; range 0..7.
- `BRAKE_DECEL`, 8: speed lost per tick while braking.

Ports:
- `clock`, input, 1: single clock, rising edge.
- `reset`, input, 1: synchronous, active-high.
- `fuel`, input, 3: throttle command from the controller, 0..7.
- `brake`, input, 1: brake request from the controller.
- `speed`, output, 8: current vehicle speed.
- `tick`, output, 1: one-cycle strobe; high in the cycle in which a new `speed` first appears.
- `state`, output, 2: motion state. STOPPED=0, ACCEL=1, COAST=2, BRAKING=3.
- `distance`, output, 16: odometer.

## Operation
- **Input registers.** `fuel` and `brake` are registered every clock into `fuel_q` and `brake_q`. All physics uses only the registered copies.
- **Tick divider.** `div_cnt` counts 0..UPDATE_DIV-1. The update edge is the edge at which `div_cnt == UPDATE_DIV-1`; on that edge `div_cnt` wraps to 0.
- **Update, brake path.** If `brake_q` is 1: `speed_next = max(speed - BRAKE_DECEL, 0)`. Fuel is ignored; brake has priority.
- **Update, no brake.** Compute the signed 10-bit value `delta = fuel_q - DRAG`, then `speed_next = clamp(speed + delta, 0, MAX_SPEED)`. The sum must not wrap at 8 bits.
- **Odometer.** `distance <= distance + speed`, using the pre-update speed. Width is 16 bits and it wraps modulo 65536.
- **State transitions.** Evaluated on the update edge, in this priority order:
  1. `speed_next == 0` → STOPPED.
  2. `brake_q` → BRAKING.
  3. `delta > 0` and `speed_next > speed` → ACCEL.
  4. Otherwise → COAST. This covers: delta == 0, delta < 0, and positive delta clipped at MAX_SPEED with no increase.
- **Between updates.** `speed`, `state` and `distance` hold their values.
- **Reset values.** `speed`=0, `distance`=0, `state`=STOPPED, `tick`=0, `div_cnt`=0, `fuel_q`=0, `brake_q`=0.
- **Reset mid-operation.** Reset overrides any pending update on the same edge. Any partially counted tick is discarded.

## Timing
- **Input latency.** A change in `fuel`/`brake` sampled at edge N is visible to the physics from edge N+1 onward. It affects the first update edge that is ≥ N+1.
- **First update after reset.** With reset low from edge R onward, update edges fall at R+UPDATE_DIV-1, then every UPDATE_DIV edges after that. Here R is the first edge at which reset is sampled low.
- **Tick alignment.** `tick` is registered high at the update edge, so it is high for exactly one cycle. That cycle coincides with the first cycle showing the new `speed`, `state` and `distance`.
- **Simultaneous changes.** `brake` and `fuel` changing together are both captured on the same edge. Brake priority then applies.
- **No combinational paths** from inputs to outputs.

## Test plan
All scenarios use default parameters.
1. **Reset.** Assert reset for 3 cycles with `fuel`=7 and `brake`=1 → `speed`=0, `distance`=0, `state`=0 and `tick`=0 throughout reset. First `tick` occurs 4 edges after reset is released (UPDATE_DIV-1 edges from R, where R is the first edge sampling reset low).
2. **Acceleration.** `fuel`=5, `brake`=0 from reset for 10 ticks → `speed` reads 4, 8, … 40; `state`=ACCEL; `distance`=180 after the 10th tick; `tick` period is 4 cycles.
3. **Saturation.** At `speed`=198 drive `fuel`=7 → next tick gives 200 (ACCEL). Following ticks hold 200 with `state`=COAST and never exceed 200.
4. **Braking.** At `speed`=20 drive `fuel`=7 and `brake`=1 → 12 (BRAKING), 4 (BRAKING), 0 (STOPPED). Further ticks stay 0 / STOPPED.
5. **Drag and hold.**
   - At `speed`=3 with `fuel`=0 → 2, 1, 0 (COAST, COAST, STOPPED), with no underflow.
   - At `speed`=50 with `fuel`=1 → `speed` holds at 50 and `state`=COAST.
6. **Mid-tick reset and input latency.**
   - Assert reset 2 cycles after a tick at `speed`=40 → all outputs zero on the next cycle; the divider restarts as in scenario 1.
   - Set `brake`=1 on the same edge as an update edge → the brake is not applied until the following tick.

Source files
------------

// File: rtl/vehicle_plant_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vehicle_plant_if : controller <-> vehicle plant command/measurement bundle  |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
interface vehicle_plant_if;
  logic [2:0]  fuel;
  logic        brake;
  logic [7:0]  speed;
  logic        tick;
  logic [1:0]  state;
  logic [15:0] distance;

  modport master (
    output fuel, brake,
    input  speed, tick, state, distance
  );

  modport slave (
    input  fuel, brake,
    output speed, tick, state, distance
  );
endinterface
`default_nettype wire

// File: rtl/vehicle_plant.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vehicle_plant : tick-based speed/odometer model driven by fuel and brake    |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module vehicle_plant #(
  parameter int MAX_SPEED   = 200,
  parameter int UPDATE_DIV  = 4,
  parameter int DRAG        = 1,
  parameter int BRAKE_DECEL = 8
) (
  input wire              clock,
  input wire              reset,
  vehicle_plant_if.slave  plant_io
);

  localparam int DIV_W = $clog2(UPDATE_DIV);
  localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(UPDATE_DIV - 1);
  localparam logic [DIV_W-1:0]   DIV_ONE  = DIV_W'(1);
  localparam logic signed [9:0]  DRAG_S   = 10'(DRAG);
  localparam logic signed [10:0] MAX_S    = 11'(MAX_SPEED);

  typedef enum logic [1:0] {
    STOPPED = 2'd0,
    ACCEL   = 2'd1,
    COAST   = 2'd2,
    BRAKING = 2'd3
  } state_e;

  logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
  logic [2:0]         fuel_q;
  logic               brake_q;
  logic [7:0]         speed_q, speed_d;
  logic [15:0]        dist_q, dist_d;
  state_e             state_q, state_d;
  logic               tick_q, tick_d;

  logic               update;
  logic signed [9:0]  delta;
  logic signed [10:0] sum;
  logic [7:0]         speed_next;
  state_e             state_next;

  always_comb begin
    update = (div_cnt_q == DIV_LAST);
    delta  = $signed({7'd0, fuel_q}) - DRAG_S;
    // 11-bit signed sum so both underflow below 0 and overshoot past 255 are visible
    sum    = $signed({3'd0, speed_q}) + $signed({delta[9], delta});

    if (brake_q) begin
      if (int'(speed_q) > BRAKE_DECEL) speed_next = speed_q - 8'(BRAKE_DECEL);
      else                             speed_next = 8'd0;
    end else if (sum < 0) begin
      speed_next = 8'd0;
    end else if (sum > MAX_S) begin
      speed_next = 8'(MAX_SPEED);
    end else begin
      speed_next = sum[7:0];
    end

    if (speed_next == 8'd0)                         state_next = STOPPED;
    else if (brake_q)                               state_next = BRAKING;
    else if ((delta > 0) && (speed_next > speed_q)) state_next = ACCEL;
    else                                            state_next = COAST;
  end

  always_comb begin
    div_cnt_d = update ? '0 : div_cnt_q + DIV_ONE;
    speed_d   = speed_q;
    state_d   = state_q;
    dist_d    = dist_q;
    tick_d    = update;
    if (update) begin
      speed_d = speed_next;
      state_d = state_next;
      // odometer integrates the speed that was in force during the elapsed tick
      dist_d  = dist_q + 16'(speed_q);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      div_cnt_q <= '0;
      fuel_q    <= 3'd0;
      brake_q   <= 1'b0;
      speed_q   <= 8'd0;
      dist_q    <= 16'd0;
      state_q   <= STOPPED;
      tick_q    <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      fuel_q    <= plant_io.fuel;
      brake_q   <= plant_io.brake;
      speed_q   <= speed_d;
      dist_q    <= dist_d;
      state_q   <= state_d;
      tick_q    <= tick_d;
    end
  end

  assign plant_io.speed    = speed_q;
  assign plant_io.tick     = tick_q;
  assign plant_io.state    = state_q;
  assign plant_io.distance = dist_q;

endmodule
`default_nettype wire

// File: tb/tb_vehicle_plant.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_vehicle_plant : tick-level vector table, corner sequences, random vs model|
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module tb_vehicle_plant;
  localparam int MAX_SPEED   = 200;
  localparam int UPDATE_DIV  = 4;
  localparam int DRAG        = 1;
  localparam int BRAKE_DECEL = 8;
  localparam int ST_STOPPED  = 0;
  localparam int ST_ACCEL    = 1;
  localparam int ST_COAST    = 2;
  localparam int ST_BRAKING  = 3;

  logic clock = 1'b0;
  logic reset = 1'b1;

  vehicle_plant_if pif();

  vehicle_plant #(
    .MAX_SPEED  (MAX_SPEED),
    .UPDATE_DIV (UPDATE_DIV),
    .DRAG       (DRAG),
    .BRAKE_DECEL(BRAKE_DECEL)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .plant_io(pif)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: counts edges since reset release; every UPDATE_DIV-th edge
  // applies the physics to the inputs seen on the previous edge.
  int m_speed = 0, m_dist = 0, m_state = 0, m_tick = 0;
  int m_n = 0, m_fuel = 0, m_brake = 0;

  task automatic model_step();
    int d, nxt;
    if (reset) begin
      m_speed = 0; m_dist = 0; m_state = ST_STOPPED; m_tick = 0;
      m_n = 0; m_fuel = 0; m_brake = 0;
    end else begin
      m_tick = ((m_n % UPDATE_DIV) == UPDATE_DIV - 1) ? 1 : 0;
      if (m_tick == 1) begin
        d = m_fuel - DRAG;
        if (m_brake != 0) begin
          nxt = (m_speed > BRAKE_DECEL) ? m_speed - BRAKE_DECEL : 0;
        end else begin
          nxt = m_speed + d;
          if (nxt < 0) nxt = 0;
          if (nxt > MAX_SPEED) nxt = MAX_SPEED;
        end
        if (nxt == 0)                      m_state = ST_STOPPED;
        else if (m_brake != 0)             m_state = ST_BRAKING;
        else if (d > 0 && nxt > m_speed)   m_state = ST_ACCEL;
        else                               m_state = ST_COAST;
        m_dist  = (m_dist + m_speed) % 65536;
        m_speed = nxt;
      end
      m_n++;
      m_fuel  = int'(pif.fuel);
      m_brake = int'(pif.brake);
    end
  endtask

  initial forever begin
    @(posedge clock);
    model_step();
  end

  typedef struct {
    int fuel;
    int brake;
    int exp_speed;
    int exp_state;
    int exp_dist;
  } vec_t;

  vec_t vecs[$];
  int   fill_speed = 0;
  int   fill_dist  = 0;

  task automatic add_vec(input int fuel, input int brake, input int sp, input int st);
    vec_t v;
    fill_dist   = (fill_dist + fill_speed) % 65536;
    fill_speed  = sp;
    v.fuel      = fuel;
    v.brake     = brake;
    v.exp_speed = sp;
    v.exp_state = st;
    v.exp_dist  = fill_dist;
    vecs.push_back(v);
  endtask

  task automatic wait_tick(output int cycles);
    cycles = 0;
    do begin
      @(negedge clock);
      cycles++;
    end while (!pif.tick && cycles < 3 * UPDATE_DIV);
    check("tick_seen", int'(pif.tick), 1);
  endtask

  task automatic check_outputs(input string tag, input int sp, input int st, input int ds);
    check({tag, "_speed"},    int'(pif.speed),    sp);
    check({tag, "_state"},    int'(pif.state),    st);
    check({tag, "_distance"}, int'(pif.distance), ds);
  endtask

  initial begin
    int cyc;
    int brake_pct;

    // acceleration, saturation, braking, drag, hold
    for (int k = 1; k <= 10; k++) add_vec(5, 0, 4 * k, ST_ACCEL);
    for (int k = 1; k <= 26; k++) add_vec(7, 0, 40 + 6 * k, ST_ACCEL);
    add_vec(3, 0, 198, ST_ACCEL);
    add_vec(7, 0, 200, ST_ACCEL);
    for (int k = 0; k < 3; k++)   add_vec(7, 0, 200, ST_COAST);
    for (int k = 1; k <= 22; k++) add_vec(7, 1, 200 - 8 * k, ST_BRAKING);
    for (int k = 1; k <= 4; k++)  add_vec(0, 0, 24 - k, ST_COAST);
    add_vec(7, 1, 12, ST_BRAKING);
    add_vec(7, 1, 4, ST_BRAKING);
    add_vec(7, 1, 0, ST_STOPPED);
    add_vec(7, 1, 0, ST_STOPPED);
    add_vec(4, 0, 3, ST_ACCEL);
    add_vec(0, 0, 2, ST_COAST);
    add_vec(0, 0, 1, ST_COAST);
    add_vec(0, 0, 0, ST_STOPPED);
    add_vec(0, 0, 0, ST_STOPPED);
    for (int k = 1; k <= 10; k++) add_vec(6, 0, 5 * k, ST_ACCEL);
    for (int k = 0; k < 3; k++)   add_vec(1, 0, 50, ST_COAST);

    // reset held 3 cycles with full throttle and brake requested
    pif.fuel  = 3'd7;
    pif.brake = 1'b1;
    reset     = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check_outputs("reset", 0, ST_STOPPED, 0);
      check("reset_tick", int'(pif.tick), 0);
    end
    reset = 1'b0;

    foreach (vecs[i]) begin
      pif.fuel  = 3'(vecs[i].fuel);
      pif.brake = vecs[i].brake[0];
      wait_tick(cyc);
      if (i == 0) check("first_tick_latency", cyc, UPDATE_DIV);
      else        check("tick_period", cyc, UPDATE_DIV);
      check_outputs($sformatf("vec%0d", i), vecs[i].exp_speed, vecs[i].exp_state,
                    vecs[i].exp_dist);
    end

    // reset two cycles into a tick interval discards everything
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check_outputs("midreset", 0, ST_STOPPED, 0);
    check("midreset_tick", int'(pif.tick), 0);
    reset     = 1'b0;
    pif.fuel  = 3'd5;
    pif.brake = 1'b0;
    wait_tick(cyc);
    check("restart_latency", cyc, UPDATE_DIV);
    check_outputs("restart", 4, ST_ACCEL, 0);

    // brake sampled on an update edge only takes effect one tick later
    repeat (UPDATE_DIV - 1) @(negedge clock);
    pif.brake = 1'b1;
    wait_tick(cyc);
    check_outputs("brake_on_edge", 8, ST_ACCEL, 4);
    wait_tick(cyc);
    check_outputs("brake_next_tick", 0, ST_STOPPED, 12);

    // randomized closed-loop-ish stimulus against the reference model
    for (int i = 0; i < 3000; i++) begin
      @(negedge clock);
      check("rnd_speed",    int'(pif.speed),    m_speed);
      check("rnd_state",    int'(pif.state),    m_state);
      check("rnd_distance", int'(pif.distance), m_dist);
      check("rnd_tick",     int'(pif.tick),     m_tick);
      brake_pct = ((i / 400) % 2 == 1) ? 50 : 12;
      pif.fuel  = 3'($urandom_range(0, 7));
      pif.brake = ($urandom_range(0, 99) < brake_pct);
      reset     = ($urandom_range(0, 299) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
